// File: rtl/router_vc_buffer_stub_if.sv
// ---------------------------------------------------------------------------
// router_vc_buffer_stub_if
//   Bundles the flit/handshake buses of router_vc_buffer_stub.
//   Port p of every bus lives at slice [p*W +: W] (W = DW, VW or NVCH).
//   Signals:
//     IDATA/IVALID/IVCH  upstream flit into the router
//     ORDY/OACK/OLCK     per-VC flow control back to upstream
//     ODATA/OVALID/OVCH  flit out of the router
//     IACK/ILCK          per-VC ready / lock from downstream
//     ERR                sticky refused-flit flag (only with
//                        ROUTER_VC_BUFFER_STUB_ERR_EN defined)
//   Modports: master = environment side, slave = router side.
// ---------------------------------------------------------------------------
interface router_vc_buffer_stub_if #(
  parameter int NPORT = 5,
  parameter int DW    = 35,
  parameter int NVCH  = 2
);
  localparam int VW = $clog2(NVCH);

  logic [NPORT*DW-1:0]   IDATA;
  logic [NPORT-1:0]      IVALID;
  logic [NPORT*VW-1:0]   IVCH;
  logic [NPORT*NVCH-1:0] ORDY;
  logic [NPORT*NVCH-1:0] OACK;
  logic [NPORT*NVCH-1:0] OLCK;
  logic [NPORT*DW-1:0]   ODATA;
  logic [NPORT-1:0]      OVALID;
  logic [NPORT*VW-1:0]   OVCH;
  logic [NPORT*NVCH-1:0] IACK;
  logic [NPORT*NVCH-1:0] ILCK;
`ifdef ROUTER_VC_BUFFER_STUB_ERR_EN
  logic [NPORT-1:0]      ERR;
`endif

  modport master (
    output IDATA, IVALID, IVCH, IACK, ILCK,
    input  ORDY, OACK, OLCK, ODATA, OVALID, OVCH
`ifdef ROUTER_VC_BUFFER_STUB_ERR_EN
    , input ERR
`endif
  );

  modport slave (
    input  IDATA, IVALID, IVCH, IACK, ILCK,
    output ORDY, OACK, OLCK, ODATA, OVALID, OVCH
`ifdef ROUTER_VC_BUFFER_STUB_ERR_EN
    , output ERR
`endif
  );
endinterface

// File: rtl/router_vc_buffer_stub.sv
// ---------------------------------------------------------------------------
// router_vc_buffer_stub
//   Buffered stand-in for the mesh router. Each input port p owns one FIFO
//   per virtual channel; all FIFOs of port p drain to output port p through
//   a round-robin VC arbiter. Gives NoC benches real flow control.
// Ports:
//   clk   rising-edge clock
//   RST   asynchronous active-high reset (release expected synchronous)
//   bus   router_vc_buffer_stub_if.slave (flit in, flow control, flit out)
// Optional feature macro: ROUTER_VC_BUFFER_STUB_ERR_EN
//   Defined  : bus.ERR[p] goes sticky-high one cycle after a refused IVALID[p]
//              (full FIFO or out-of-range VC); cleared only by RST.
//   Undefined: no ERR signal, refused flits are dropped silently.
// ---------------------------------------------------------------------------
module router_vc_buffer_stub #(
  parameter int NPORT = 5,
  parameter int DW    = 35,
  parameter int NVCH  = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  router_vc_buffer_stub_if.slave bus
);
  localparam int VW = $clog2(NVCH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [NPORT-1:0][DW-1:0]   odata_all;
  logic [NPORT-1:0][VW-1:0]   ovch_all;
  logic [NPORT-1:0]           ovalid_all;
  logic [NPORT-1:0][NVCH-1:0] ordy_all;
  logic [NPORT-1:0][NVCH-1:0] oack_all;
  logic [NPORT-1:0][NVCH-1:0] olck_all;

  assign bus.ODATA  = odata_all;
  assign bus.OVCH   = ovch_all;
  assign bus.OVALID = ovalid_all;
  assign bus.ORDY   = ordy_all;
  assign bus.OACK   = oack_all;
  assign bus.OLCK   = olck_all;

`ifdef ROUTER_VC_BUFFER_STUB_ERR_EN
  logic [NPORT-1:0] err_all;
  assign bus.ERR = err_all;
`endif

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic [DW-1:0]   idata;
    logic            ivalid;
    logic [VW-1:0]   ivch;
    logic [NVCH-1:0] iack;
    logic [NVCH-1:0] ilck;

    assign idata  = bus.IDATA[gi*DW +: DW];
    assign ivalid = bus.IVALID[gi];
    assign ivch   = bus.IVCH[gi*VW +: VW];
    assign iack   = bus.IACK[gi*NVCH +: NVCH];
    assign ilck   = bus.ILCK[gi*NVCH +: NVCH];

    // Flit storage: written on push, read at the head when granted.
    logic [DW-1:0] mem [NVCH][DEPTH];

    logic [CW-1:0]   count_q [NVCH];
    logic [CW-1:0]   count_d [NVCH];
    logic [PW-1:0]   wptr_q  [NVCH];
    logic [PW-1:0]   wptr_d  [NVCH];
    logic [PW-1:0]   rptr_q  [NVCH];
    logic [PW-1:0]   rptr_d  [NVCH];
    logic [VW-1:0]   rr_q, rr_d;
    logic [DW-1:0]   odata_q, odata_d;
    logic [VW-1:0]   ovch_q, ovch_d;
    logic            ovalid_q, ovalid_d;
    logic [NVCH-1:0] oack_q, oack_d;
    logic [NVCH-1:0] olck_q, olck_d;
    logic [NVCH-1:0] ordy;
    logic [NVCH-1:0] push;
    logic [NVCH-1:0] pop;
    logic            grant;
    logic [VW-1:0]   gnt_vc;

    // Readiness depends only on the registered count, so a FIFO that is full
    // at the start of the cycle refuses a push even if it pops this cycle.
    for (genvar gj = 0; gj < NVCH; gj++) begin : g_rdy
      assign ordy[gj] = (count_q[gj] < CW'(DEPTH));
    end

    // An out-of-range VC matches no FIFO, so that flit is never pushed.
    always_comb begin
      push = '0;
      for (int v = 0; v < NVCH; v++) begin
        if (ivalid && (ivch == VW'(v)) && ordy[v]) begin
          push[v] = 1'b1;
        end
      end
    end

    // Round-robin search starting at rr_q, wrapping NVCH-1 -> 0.
    always_comb begin : arb
      int idx;
      idx    = 0;
      grant  = 1'b0;
      gnt_vc = '0;
      for (int k = 0; k < NVCH; k++) begin
        idx = (int'(rr_q) + k) % NVCH;
        if (!grant && (count_q[idx] != '0) && iack[idx]) begin
          grant  = 1'b1;
          gnt_vc = VW'(idx);
        end
      end
    end

    always_comb begin
      pop = '0;
      for (int v = 0; v < NVCH; v++) begin
        pop[v]     = grant && (gnt_vc == VW'(v));
        count_d[v] = count_q[v];
        wptr_d[v]  = wptr_q[v];
        rptr_d[v]  = rptr_q[v];
        if (push[v]) wptr_d[v] = wptr_q[v] + 1'b1;
        if (pop[v])  rptr_d[v] = rptr_q[v] + 1'b1;
        // Push and pop together leave the count unchanged.
        if (push[v] && !pop[v]) begin
          count_d[v] = count_q[v] + 1'b1;
        end else if (!push[v] && pop[v]) begin
          count_d[v] = count_q[v] - 1'b1;
        end
      end

      rr_d     = rr_q;
      ovalid_d = grant;
      odata_d  = odata_q;
      ovch_d   = ovch_q;
      if (grant) begin
        odata_d = mem[gnt_vc][rptr_q[gnt_vc]];
        ovch_d  = gnt_vc;
        rr_d    = (gnt_vc == VW'(NVCH - 1)) ? '0 : gnt_vc + 1'b1;
      end
      oack_d = push;
      olck_d = ilck;
    end

    always_ff @(posedge clk) begin
      for (int v = 0; v < NVCH; v++) begin
        if (push[v]) mem[v][wptr_q[v]] <= idata;
      end
    end

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        for (int v = 0; v < NVCH; v++) begin
          count_q[v] <= '0;
          wptr_q[v]  <= '0;
          rptr_q[v]  <= '0;
        end
        rr_q     <= '0;
        odata_q  <= '0;
        ovch_q   <= '0;
        ovalid_q <= 1'b0;
        oack_q   <= '0;
        olck_q   <= '0;
      end else begin
        for (int v = 0; v < NVCH; v++) begin
          count_q[v] <= count_d[v];
          wptr_q[v]  <= wptr_d[v];
          rptr_q[v]  <= rptr_d[v];
        end
        rr_q     <= rr_d;
        odata_q  <= odata_d;
        ovch_q   <= ovch_d;
        ovalid_q <= ovalid_d;
        oack_q   <= oack_d;
        olck_q   <= olck_d;
      end
    end

    assign odata_all[gi]  = odata_q;
    assign ovch_all[gi]   = ovch_q;
    assign ovalid_all[gi] = ovalid_q;
    assign ordy_all[gi]   = ordy;
    assign oack_all[gi]   = oack_q;
    assign olck_all[gi]   = olck_q;

`ifdef ROUTER_VC_BUFFER_STUB_ERR_EN
    logic err_q, err_d;
    // Any valid flit that was not pushed counts as refused.
    assign err_d = err_q | (ivalid & ~(|push));
    always_ff @(posedge clk or posedge RST) begin
      if (RST) err_q <= 1'b0;
      else     err_q <= err_d;
    end
    assign err_all[gi] = err_q;
`endif
  end

endmodule

// File: tb/tb_router_vc_buffer_stub.sv
module tb_router_vc_buffer_stub;
  localparam int NPORT = 5;
  localparam int DW    = 35;
  localparam int NVCH  = 2;
  localparam int DEPTH = 4;
  localparam int VW    = $clog2(NVCH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_vc_buffer_stub_if #(.NPORT(NPORT), .DW(DW), .NVCH(NVCH)) bus ();

  router_vc_buffer_stub #(.NPORT(NPORT), .DW(DW), .NVCH(NVCH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  // Expected DUT outputs after one clock edge.
  typedef struct packed {
    logic [NPORT-1:0]      ovalid;
    logic [NPORT*DW-1:0]   odata;
    logic [NPORT*VW-1:0]   ovch;
    logic [NPORT*NVCH-1:0] oack;
    logic [NPORT*NVCH-1:0] olck;
    logic [NPORT*NVCH-1:0] ordy;
    logic [NPORT-1:0]      err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: one queue per (port, VC), RR pointer as a plain int.
  logic [DW-1:0] mq [NPORT][NVCH][$];
  int            rr_m      [NPORT];
  logic [DW-1:0] last_data [NPORT];
  int            last_vc   [NPORT];
  logic [NPORT-1:0] err_m;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string name, int p, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s port%0d: got %h, expected %h at %0t", name, p, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] rnd_flit();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Advance the model by one clock edge using the inputs now on the bus.
  task automatic model_step();
    exp_t e;
    e = '0;
    if (rst) begin
      for (int p = 0; p < NPORT; p++) begin
        for (int v = 0; v < NVCH; v++) mq[p][v].delete();
        rr_m[p] = 0;
        last_data[p] = '0;
        last_vc[p] = 0;
      end
      err_m  = '0;
      e.ordy = '1;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        int g;
        int vch;
        bit acc;
        g = -1;
        for (int k = 0; k < NVCH; k++) begin
          int v;
          v = (rr_m[p] + k) % NVCH;
          if (g < 0 && mq[p][v].size() != 0 && bus.IACK[p*NVCH+v]) g = v;
        end
        vch = int'(bus.IVCH[p*VW +: VW]);
        acc = 1'b0;
        if (bus.IVALID[p] && vch < NVCH) acc = (mq[p][vch].size() < DEPTH);
        if (g >= 0) begin
          last_data[p] = mq[p][g].pop_front();
          last_vc[p]   = g;
          rr_m[p]      = (g + 1) % NVCH;
          e.ovalid[p]  = 1'b1;
        end
        if (acc) begin
          mq[p][vch].push_back(bus.IDATA[p*DW +: DW]);
          e.oack[p*NVCH+vch] = 1'b1;
        end else if (bus.IVALID[p]) begin
          err_m[p] = 1'b1;
        end
        e.odata[p*DW +: DW] = last_data[p];
        e.ovch[p*VW +: VW]  = VW'(last_vc[p]);
        for (int v = 0; v < NVCH; v++) e.ordy[p*NVCH+v] = (mq[p][v].size() < DEPTH);
      end
      e.olck = bus.ILCK;
    end
    e.err = err_m;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.IVALID = '0;
    bus.IVCH   = '0;
    bus.IACK   = '1;
    bus.ILCK   = NPORT*NVCH'($urandom());
    for (int p = 0; p < NPORT; p++) bus.IDATA[p*DW +: DW] = rnd_flit();
  endtask

  task automatic set_push(int p, int v, logic [DW-1:0] d);
    bus.IVALID[p]        = 1'b1;
    bus.IVCH[p*VW +: VW] = VW'(v);
    bus.IDATA[p*DW +: DW] = d;
  endtask

  task automatic set_random();
    for (int p = 0; p < NPORT; p++) begin
      bus.IVALID[p]         = ($urandom_range(0, 3) != 0);
      bus.IVCH[p*VW +: VW]  = VW'($urandom());
      bus.IDATA[p*DW +: DW] = rnd_flit();
    end
    for (int i = 0; i < NPORT*NVCH; i++) bus.IACK[i] = ($urandom_range(0, 2) != 0);
    bus.ILCK = NPORT*NVCH'($urandom());
  endtask

  // Monitor: after every edge, pop the expectation and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int p = 0; p < NPORT; p++) begin
          chk("OVALID", p, 64'(bus.OVALID[p]), 64'(e.ovalid[p]));
          chk("ODATA",  p, 64'(bus.ODATA[p*DW +: DW]), 64'(e.odata[p*DW +: DW]));
          chk("OVCH",   p, 64'(bus.OVCH[p*VW +: VW]), 64'(e.ovch[p*VW +: VW]));
          chk("OACK",   p, 64'(bus.OACK[p*NVCH +: NVCH]), 64'(e.oack[p*NVCH +: NVCH]));
          chk("OLCK",   p, 64'(bus.OLCK[p*NVCH +: NVCH]), 64'(e.olck[p*NVCH +: NVCH]));
          chk("ORDY",   p, 64'(bus.ORDY[p*NVCH +: NVCH]), 64'(e.ordy[p*NVCH +: NVCH]));
`ifdef ROUTER_VC_BUFFER_STUB_ERR_EN
          chk("ERR",    p, 64'(bus.ERR[p]), 64'(e.err[p]));
`endif
        end
      end
    end
  end

  initial begin
    bus.IDATA  = '0;
    bus.IVALID = '0;
    bus.IVCH   = '0;
    bus.IACK   = '0;
    bus.ILCK   = '0;
    @(negedge clk);

    // Reset held with junk on every input.
    for (int i = 0; i < 3; i++) begin
      set_random();
      tick();
    end
    rst = 1'b0;

    // Single flit latency: port0 VC1.
    set_idle();
    tick();
    set_idle();
    set_push(0, 1, 35'h1_2345_6789);
    tick();
    for (int i = 0; i < 3; i++) begin set_idle(); tick(); end

    // Backpressure on port2 VC0: five pushes, fifth refused.
    for (int i = 0; i < 5; i++) begin
      set_idle();
      bus.IACK[2*NVCH+0] = 1'b0;
      set_push(2, 0, DW'(100 + i));
      tick();
    end
    set_idle();
    bus.IACK[2*NVCH+0] = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin set_idle(); tick(); end

    // Round-robin: port1 VC0 and VC1 each get 3 flits while blocked.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      bus.IACK[1*NVCH+0] = 1'b0;
      bus.IACK[1*NVCH+1] = 1'b0;
      set_push(1, i / 3, DW'(200 + i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin set_idle(); tick(); end

    // Full FIFO with simultaneous pop and push on port3 VC0.
    for (int i = 0; i < 4; i++) begin
      set_idle();
      bus.IACK[3*NVCH+0] = 1'b0;
      set_push(3, 0, DW'(300 + i));
      tick();
    end
    set_idle();
    set_push(3, 0, DW'(399));
    tick();
    for (int i = 0; i < 6; i++) begin set_idle(); tick(); end

    // Mid-operation reset with flits buffered and flowing.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      for (int p = 0; p < NPORT; p++) set_push(p, i % NVCH, rnd_flit());
      if (i < 4) bus.IACK[2*NVCH +: NVCH] = '0;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("OVALID_ASYNC_RST", 0, 64'(bus.OVALID), 64'(0));
    chk("OACK_ASYNC_RST",   0, 64'(bus.OACK), 64'(0));
    set_random();
    tick();
    set_random();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin set_idle(); tick(); end

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      set_random();
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin set_idle(); tick(); end

    #2;
    chk("SCOREBOARD_DRAIN", 0, 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
